inst_fetch_icache: RTL and testbench

Parametrised instruction-fetch stage with an integrated direct-mapped instruction cache, placed between the PC register and IF_ID, and connected to the memory controller's word-read port. Cache hits return an instruction in the cycle the PC is presented. Misses issue one whole-word read to the memory controller, refill the line, and replay the lookup. The block also provides a pipeline stall request, a fence.i-style invalidate, and saturating hit/miss performance counters.

---
 rtl/inst_fetch_icache.sv | 137 +++++++++++++
 tb/tb_inst_fetch_icache.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_icache.sv
// Instruction fetch stage with a direct-mapped one-word-per-line I-cache.
// Ports: clk_i/rst_n_i; PC in (pc_valid_i, pc_i, stall_i, flush_i,
//   invalidate_i); MEMCTRL word read (mem_req_o, mem_addr_o, mem_done_i,
//   mem_rdata_i); IF_ID out (inst_valid_o, inst_o, inst_pc_o, next_pc_o);
//   stall_req_o; saturating hit_cnt_o / miss_cnt_o.
module inst_fetch_icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int CACHE_LINES = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pc_valid_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  invalidate_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_done_i,
    input  logic [INST_WIDTH-1:0] mem_rdata_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  stall_req_o,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
    localparam int IDX  = $clog2(CACHE_LINES);
    localparam int TAGW = ADDR_WIDTH - IDX - 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MISS = 1'b1;

    logic [0:0]            r_state;
    logic [CACHE_LINES-1:0] r_valid;
    logic [TAGW-1:0]       r_tag  [CACHE_LINES];
    logic [INST_WIDTH-1:0] r_data [CACHE_LINES];
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic                  r_req;
    logic                  r_cancel;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic [IDX-1:0]        w_idx;
    logic [TAGW-1:0]       w_tag;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [IDX-1:0]        w_fill_idx;
    logic [TAGW-1:0]       w_fill_tag;
    logic                  w_hit;
    logic                  w_out;
    logic                  w_start;
    logic                  w_done;
    logic                  w_fill;
    logic                  w_accept;
    logic                  w_unused;

    assign w_idx      = pc_i[IDX+1:2];
    assign w_tag      = pc_i[ADDR_WIDTH-1:IDX+2];
    assign w_pc       = {pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_fill_idx = r_miss_addr[IDX+1:2];
    assign w_fill_tag = r_miss_addr[ADDR_WIDTH-1:IDX+2];
    assign w_unused   = ^pc_i[1:0];

    // An invalidate in the same cycle hides every line, so no hit.
    assign w_hit = (r_state == ST_IDLE) && pc_valid_i && !invalidate_i
                 && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_out    = w_hit && !flush_i;
    assign w_accept = w_out && !stall_i;
    assign w_start  = (r_state == ST_IDLE) && pc_valid_i && !w_hit
                    && !flush_i && !invalidate_i;
    assign w_done   = (r_state == ST_MISS) && mem_done_i;
    // Flush does not block the fill: the data is still right for miss_addr.
    assign w_fill   = w_done && !r_cancel && !invalidate_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_miss_addr <= '0;
            r_cancel    <= 1'b0;
        end else begin
            if (w_start) begin
                r_state     <= ST_MISS;
                r_req       <= 1'b1;
                r_miss_addr <= w_pc;
            end else if (w_done) begin
                r_state <= ST_IDLE;
                r_req   <= 1'b0;
            end
            if (w_done)
                r_cancel <= 1'b0;
            else if (r_state == ST_MISS && invalidate_i)
                r_cancel <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_valid <= '0;
        else if (invalidate_i)
            r_valid <= '0;
        else if (w_fill)
            r_valid[w_fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_start && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign mem_req_o    = r_req;
    assign mem_addr_o   = r_miss_addr;
    assign inst_valid_o = w_out;
    assign inst_o       = w_out ? r_data[w_idx] : '0;
    assign inst_pc_o    = w_out ? w_pc : '0;
    assign next_pc_o    = w_out ? w_pc + ADDR_WIDTH'(4) : '0;
    assign stall_req_o  = pc_valid_i && !w_out && !flush_i;
    assign hit_cnt_o    = r_hit_cnt;
    assign miss_cnt_o   = r_miss_cnt;
endmodule

// File: tb/tb_inst_fetch_icache.sv
// Self-checking bench for inst_fetch_icache: table vectors, scoreboard,
// and hand sequences for miss/flush/invalidate/saturation/wrap.
module tb_inst_fetch_icache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_valid_i, stall_i, flush_i, invalidate_i;
    logic [31:0] pc_i;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o, inst_valid_o, stall_req_o;
    logic [31:0] mem_addr_o, inst_o, inst_pc_o, next_pc_o;
    logic [15:0] hit_cnt_o, miss_cnt_o;
    logic        d2_req, d2_valid, d2_sreq;
    logic [31:0] d2_addr, d2_inst, d2_ipc, d2_npc;
    logic [1:0]  d2_hit, d2_miss;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;
    int exp_hits = 0;
    int exp_miss = 0;
    int last_n = 0;
    logic [31:0] rd_q[$];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] npc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic        esr;
        int          einc;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    inst_fetch_icache dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .invalidate_i(invalidate_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .next_pc_o(next_pc_o),
        .stall_req_o(stall_req_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    inst_fetch_icache #(.CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .invalidate_i(invalidate_i),
        .mem_req_o(d2_req), .mem_addr_o(d2_addr),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(d2_valid), .inst_o(d2_inst),
        .inst_pc_o(d2_ipc), .next_pc_o(d2_npc),
        .stall_req_o(d2_sreq),
        .hit_cnt_o(d2_hit), .miss_cnt_o(d2_miss)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory controller model: answers mem_lat cycles after request.
    initial begin
        int cnt;
        cnt = 0;
        mem_done_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_done_i = 1'b0;
            mem_rdata_i = '0;
            if (mem_req_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_done_i = 1'b1;
                    mem_rdata_i = memf(mem_addr_o);
                    rd_q.push_back(mem_addr_o);
                    cnt = 0;
                end
            end
        end
    end

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_inst"}, inst_o, e.inst);
        chk({nm, "_pc"}, inst_pc_o, e.pc);
        chk({nm, "_npc"}, next_pc_o, e.npc);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!inst_valid_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_n = n;
        if (!inst_valid_o) begin
            chk({nm, "_timeout"}, 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            pop_check(nm);
            exp_hits++;
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit miss,
                         input int lat);
        mem_lat = lat;
        @(negedge clk);
        pc_valid_i = 1'b1;
        pc_i = pc;
        stall_i = 1'b0;
        flush_i = 1'b0;
        invalidate_i = 1'b0;
        sb.push_back('{pc, memf(pc), pc + 32'd4});
        #1;
        chk("fetch_first_valid", inst_valid_o, !miss);
        if (miss) exp_miss++;
        wait_valid("fetch");
        @(negedge clk);
        pc_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] h0;
        rst_n = 1'b0;
        pc_valid_i = 1'b0;
        pc_i = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        invalidate_i = 1'b0;

        tbl[0] = '{1, 32'h100, 1, 0, 1, 32'h00500093, 32'h100, 0, 0};
        tbl[1] = '{1, 32'h100, 1, 0, 1, 32'h00500093, 32'h100, 0, 0};
        tbl[2] = '{1, 32'h100, 0, 0, 1, 32'h00500093, 32'h100, 0, 1};
        tbl[3] = '{1, 32'h102, 0, 0, 1, 32'h00500093, 32'h100, 0, 1};
        tbl[4] = '{1, 32'h100, 1, 1, 0, 32'h0, 32'h0, 0, 0};
        tbl[5] = '{0, 32'h100, 0, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[6] = '{1, 32'h104, 0, 1, 0, 32'h0, 32'h0, 0, 0};
        tbl[7] = '{0, 32'h104, 0, 0, 0, 32'h0, 32'h0, 0, 0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_hit", hit_cnt_o, 0);
        chk("rst_miss", miss_cnt_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_sreq", stall_req_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, three cycle memory latency.
        fetch(32'h100, 1, 3);
        chk("cold_lat", last_n, 4);
        chk("cold_reads", rd_q.size(), 1);
        if (rd_q.size() > 0) chk("cold_addr", rd_q[0], 32'h100);
        chk("cold_miss_cnt", miss_cnt_o, 1);

        // Hits with stall/flush combinations.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pc_valid_i = tbl[i].pv;
            pc_i = tbl[i].pc;
            stall_i = tbl[i].st;
            flush_i = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_valid", i), inst_valid_o, tbl[i].ev);
            chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].ei);
            chk($sformatf("tbl%0d_pc", i), inst_pc_o, tbl[i].epc);
            chk($sformatf("tbl%0d_npc", i), next_pc_o,
                tbl[i].ev ? tbl[i].epc + 32'd4 : 32'd0);
            chk($sformatf("tbl%0d_sreq", i), stall_req_o, tbl[i].esr);
            chk($sformatf("tbl%0d_req", i), mem_req_o, 0);
            h0 = hit_cnt_o;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_hitinc", i), hit_cnt_o - h0,
                16'(tbl[i].einc));
            exp_hits += tbl[i].einc;
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        chk("tbl_hit_cnt", hit_cnt_o, exp_hits);

        // Conflict misses at minimum latency.
        fetch(32'h200, 1, 1);
        chk("conf_lat", last_n, 2);
        fetch(32'h100, 1, 1);
        chk("conf_miss_cnt", miss_cnt_o, 3);
        chk("conf_d2_miss", d2_miss, 3);

        // Flush during a miss.
        fetch(32'h200, 1, 1);
        rd_q.delete();
        mem_lat = 3;
        @(negedge clk);
        pc_valid_i = 1'b1;
        pc_i = 32'h100;
        #1;
        chk("fl_first", inst_valid_o, 0);
        @(negedge clk);
        pc_i = 32'h300;
        flush_i = 1'b1;
        sb.push_back('{32'h300, memf(32'h300), 32'h304});
        #1;
        chk("fl_valid", inst_valid_o, 0);
        chk("fl_sreq", stall_req_o, 0);
        chk("fl_req", mem_req_o, 1);
        chk("fl_addr", mem_addr_o, 32'h100);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        wait_valid("fl");
        exp_miss += 2;
        chk("fl_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            chk("fl_rd0", rd_q[0], 32'h100);
            chk("fl_rd1", rd_q[1], 32'h300);
        end
        @(negedge clk);
        pc_valid_i = 1'b0;

        // Invalidate during a miss.
        fetch(32'h104, 1, 1);
        rd_q.delete();
        mem_lat = 3;
        @(negedge clk);
        pc_valid_i = 1'b1;
        pc_i = 32'h100;
        sb.push_back('{32'h100, 32'h00500093, 32'h104});
        @(negedge clk);
        invalidate_i = 1'b1;
        #1;
        chk("inv_req", mem_req_o, 1);
        @(negedge clk);
        invalidate_i = 1'b0;
        #1;
        wait_valid("inv");
        exp_miss += 2;
        chk("inv_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) chk("inv_rd1", rd_q[1], 32'h100);
        @(negedge clk);
        pc_valid_i = 1'b0;
        fetch(32'h104, 1, 1);

        // Invalidate while idle on a resident line.
        @(negedge clk);
        pc_valid_i = 1'b1;
        pc_i = 32'h100;
        invalidate_i = 1'b1;
        #1;
        chk("invi_valid", inst_valid_o, 0);
        chk("invi_sreq", stall_req_o, 1);
        @(negedge clk);
        invalidate_i = 1'b0;
        pc_valid_i = 1'b0;
        #1;
        chk("invi_req", mem_req_o, 0);
        fetch(32'h104, 1, 1);
        fetch(32'h100, 1, 1);

        // Counter saturation and PC wrap.
        for (int i = 0; i < 5; i++) fetch(32'h100, 0, 1);
        fetch(32'hFFFF_FFFC, 1, 1);
        chk("end_hit_cnt", hit_cnt_o, exp_hits);
        chk("end_miss_cnt", miss_cnt_o, exp_miss);
        chk("sat_hit", d2_hit, 2'd3);
        chk("sat_miss", d2_miss, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
